// File: rtl/toggle_counter.sv
// Up/down counter with load, clear, terminal-count pulse and sticky overflow.
// Counts over 0..MAX, wrapping or saturating at the limits.
module toggle_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX      = (2 ** WIDTH) - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic             tc,
    output logic             ovf
);

    generate
        if (MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_max
            $error("toggle_counter: MAX out of range for WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             at_max, at_zero;

    assign at_max  = (q_q == MAX_V);
    assign at_zero = (q_q == ZERO);

    // clr beats load beats en; tc defaults low so it only pulses on a boundary
    always_comb begin
        q_d   = q_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (clr) begin
            q_d   = ZERO;
            ovf_d = 1'b0;
        end else if (load) begin
            q_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    q_d   = SATURATE ? MAX_V : ZERO;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    q_d = q_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    q_d   = SATURATE ? ZERO : MAX_V;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    q_d = q_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            q_q   <= ZERO;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q     = q_q;
    assign q_not = ~q_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_toggle_counter.sv
// Directed bench for toggle_counter: wrap (MAX=9), saturate (MAX=9)
// and default-parameter instances share one stimulus set.
module tb_toggle_counter;

    logic       clk = 1'b0;
    logic       r_n;
    logic       en, up, load, clr;
    logic [3:0] load_val;

    logic [3:0] q_a, qn_a, q_s, qn_s, q_d, qn_d;
    logic       tc_a, ovf_a, tc_s, ovf_s, tc_d, ovf_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    toggle_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) dut_a (
        .clk(clk), .r_n(r_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr(clr),
        .q(q_a), .q_not(qn_a), .tc(tc_a), .ovf(ovf_a)
    );

    toggle_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) dut_s (
        .clk(clk), .r_n(r_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr(clr),
        .q(q_s), .q_not(qn_s), .tc(tc_s), .ovf(ovf_s)
    );

    toggle_counter dut_d (
        .clk(clk), .r_n(r_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr(clr),
        .q(q_d), .q_not(qn_d), .tc(tc_d), .ovf(ovf_d)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        r_n = 1'b0; en = 1'b1; up = 1'b1;
        load = 1'b0; clr = 1'b0; load_val = 4'd0;
        #3;
        checks++;
        if (q_a !== 4'd0 || tc_a !== 1'b0 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state q=%0d tc=%b ovf=%b want 0 0 0", q_a, tc_a, ovf_a);
        end
        checks++;
        if (qn_a !== 4'hF || qn_s !== 4'hF || qn_d !== 4'hF) begin
            errors++;
            $display("FAIL reset_qnot got %h %h %h want f f f", qn_a, qn_s, qn_d);
        end
        step();
        checks++;
        if (q_a !== 4'd0 || q_d !== 4'd0) begin
            errors++;
            $display("FAIL reset_ignores_en q_a=%0d q_d=%0d want 0 0", q_a, q_d);
        end
        #2 r_n = 1'b1;
        en = 1'b0;
    endtask

    task automatic test_count_up();
        logic [3:0] ea;
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            ea = (i == 10) ? 4'd0 : 4'(i);
            checks++;
            if (q_a !== ea || tc_a !== (i == 10)) begin
                errors++;
                $display("FAIL count_up[%0d] q=%0d tc=%b want %0d %b", i, q_a, tc_a, ea, i == 10);
            end
            checks++;
            if (qn_d !== ~q_d || q_d !== 4'(i)) begin
                errors++;
                $display("FAIL default_qnot[%0d] q=%0d qn=%h want q=%0d qn=~q", i, q_d, qn_d, i);
            end
        end
        checks++;
        if (ovf_a !== 1'b1 || ovf_d !== 1'b0) begin
            errors++;
            $display("FAIL count_up_ovf got a=%b d=%b want 1 0", ovf_a, ovf_d);
        end
        checks++;
        if (q_s !== 4'd9 || tc_s !== 1'b1 || ovf_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_up_hold q=%0d tc=%b ovf=%b want 9 1 1", q_s, tc_s, ovf_s);
        end
    endtask

    task automatic test_hold();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (q_a !== 4'd0 || tc_a !== 1'b0 || ovf_a !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d] q=%0d tc=%b ovf=%b want 0 0 1", i, q_a, tc_a, ovf_a);
            end
        end
    endtask

    task automatic test_saturate_down();
        logic [3:0] ea;
        clr = 1'b1;
        step();
        checks++;
        if (q_s !== 4'd0 || ovf_s !== 1'b0 || ovf_a !== 1'b0 || tc_s !== 1'b0) begin
            errors++;
            $display("FAIL clear q_s=%0d ovf_s=%b ovf_a=%b want 0 0 0", q_s, ovf_s, ovf_a);
        end
        clr = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (q_s !== 4'd0 || tc_s !== 1'b1 || ovf_s !== 1'b1) begin
                errors++;
                $display("FAIL sat_down[%0d] q=%0d tc=%b ovf=%b want 0 1 1", i, q_s, tc_s, ovf_s);
            end
            ea = 4'(10 - i);
            checks++;
            if (q_a !== ea || tc_a !== (i == 1) || ovf_a !== 1'b1) begin
                errors++;
                $display("FAIL wrap_down[%0d] q=%0d tc=%b want %0d %b", i, q_a, tc_a, ea, i == 1);
            end
        end
    endtask

    task automatic test_direction();
        en = 1'b1; up = 1'b1;
        step();
        checks++;
        if (q_a !== 4'd8) begin
            errors++;
            $display("FAIL dir_up q=%0d want 8", q_a);
        end
        up = 1'b0;
        step();
        checks++;
        if (q_a !== 4'd7) begin
            errors++;
            $display("FAIL dir_down q=%0d want 7", q_a);
        end
    endtask

    task automatic test_load_clamp();
        en = 1'b0; load = 1'b1; load_val = 4'd15;
        step();
        checks++;
        if (q_a !== 4'd9 || q_s !== 4'd9 || q_d !== 4'd15 || tc_a !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp q=%0d/%0d/%0d tc=%b want 9/9/15 0", q_a, q_s, q_d, tc_a);
        end
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        checks++;
        if (q_a !== 4'd0 || tc_a !== 1'b1) begin
            errors++;
            $display("FAIL load_then_wrap q=%0d tc=%b want 0 1", q_a, tc_a);
        end
        checks++;
        if (q_d !== 4'd0 || tc_d !== 1'b1 || ovf_d !== 1'b1 || qn_d !== 4'hF) begin
            errors++;
            $display("FAIL default_wrap q=%0d tc=%b ovf=%b qn=%h want 0 1 1 f", q_d, tc_d, ovf_d, qn_d);
        end
    endtask

    task automatic test_priority();
        load = 1'b1; load_val = 4'd3; en = 1'b1; up = 1'b1;
        step();
        checks++;
        if (q_a !== 4'd3 || tc_a !== 1'b0 || ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL load_over_en q=%0d tc=%b ovf=%b want 3 0 1", q_a, tc_a, ovf_a);
        end
        load_val = 4'd5; en = 1'b0;
        step();
        clr = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1;
        step();
        checks++;
        if (q_a !== 4'd0 || ovf_a !== 1'b0 || tc_a !== 1'b0) begin
            errors++;
            $display("FAIL clr_over_all q=%0d ovf=%b tc=%b want 0 0 0", q_a, ovf_a, tc_a);
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 4'd8;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        step();
        en = 1'b0; load = 1'b1; load_val = 4'd5;
        step();
        load = 1'b0; en = 1'b1;
        step();
        checks++;
        if (q_a !== 4'd6 || ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset q=%0d ovf=%b want 6 1", q_a, ovf_a);
        end
        #2 r_n = 1'b0;
        #1;
        checks++;
        if (q_a !== 4'd0 || tc_a !== 1'b0 || ovf_a !== 1'b0 || qn_a !== 4'hF) begin
            errors++;
            $display("FAIL async_reset q=%0d tc=%b ovf=%b qn=%h want 0 0 0 f", q_a, tc_a, ovf_a, qn_a);
        end
        step();
        checks++;
        if (q_a !== 4'd0) begin
            errors++;
            $display("FAIL reset_held q=%0d want 0", q_a);
        end
        #2 r_n = 1'b1;
        step();
        checks++;
        if (q_a !== 4'd1 || tc_a !== 1'b0) begin
            errors++;
            $display("FAIL resume q=%0d tc=%b want 1 0", q_a, tc_a);
        end
        step();
        checks++;
        if (q_a !== 4'd2) begin
            errors++;
            $display("FAIL resume2 q=%0d want 2", q_a);
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_hold();
        test_saturate_down();
        test_direction();
        test_load_clamp();
        test_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/toggle_counter.md
TOGGLE_COUNTER -- requirements
Module: toggle_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 Parameter MAX, default 2**WIDTH-1, terminal count value.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at limits, 1 = hold at limits.
REQ-004 clk  input  1  clock; all state changes on rising edge except reset.
REQ-005 r_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  count enable; one step per clk edge while high.
REQ-007 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value for load.
REQ-010 clr  input  1  synchronous clear.
REQ-011 q  output  WIDTH  registered count.
REQ-012 q_not  output  WIDTH  bitwise complement of q.
REQ-013 tc  output  1  registered terminal-count pulse.
REQ-014 ovf  output  1  sticky over/underflow flag.

Function
REQ-015 Per-edge priority SHALL be clr > load > en; lower-priority inputs are ignored that cycle.
REQ-016 clr SHALL set q=0, tc=0, ovf=0 on the next edge.
REQ-017 load SHALL set q=min(load_val, MAX) and tc=0 on the next edge; ovf unchanged.
REQ-018 en=0 with no clr/load SHALL hold q and ovf; tc=0.
REQ-019 en=1, up=1, q<MAX: q SHALL become q+1; tc=0.
REQ-020 en=1, up=1, q==MAX: q SHALL become 0 (SATURATE=0) or stay MAX (SATURATE=1); tc=1, ovf=1.
REQ-021 en=1, up=0, q>0: q SHALL become q-1; tc=0.
REQ-022 en=1, up=0, q==0: q SHALL become MAX (SATURATE=0) or stay 0 (SATURATE=1); tc=1, ovf=1.
REQ-023 tc SHALL be high for exactly the one cycle following each boundary event; consecutive boundary events (saturated hold with en=1) SHALL keep tc high each cycle.
REQ-024 q SHALL never exceed MAX.
REQ-025 q_not SHALL equal ~q combinationally at all times, including during reset.
REQ-026 ovf SHALL remain 1 until clr or reset.
REQ-027 Direction change SHALL take effect on the same edge up changes are sampled; no latency beyond one clock.
REQ-028 MAX < 1 or MAX > 2**WIDTH-1 SHALL be an elaboration error.

Reset
REQ-029 r_n=0 SHALL immediately force q=0, tc=0, ovf=0, independent of clk.
REQ-030 While r_n=0, all synchronous inputs SHALL be ignored.
REQ-031 Reset asserted mid-count SHALL discard the pending step; first step after release occurs on the first clk edge with r_n=1.
REQ-032 Out of reset q_not SHALL read all ones.

Verification (WIDTH=4, MAX=9 unless stated)
REQ-033 Reset then en=1, up=1 for 10 edges -> q 1..9 then 0; tc=1 only after the 10th edge; ovf=1.
REQ-034 SATURATE=1, q=0, en=1, up=0 for 3 edges -> q stays 0; tc=1 for all 3 cycles; ovf=1.
REQ-035 load=1, load_val=15 -> q=9 (clamped); then en=1, up=1 -> q=0, tc=1.
REQ-036 clr=1, load=1, en=1 with q=5, ovf=1 on the same edge -> q=0, ovf=0, tc=0.
REQ-037 q=6 counting, r_n pulsed low between edges -> q=0, tc=0, ovf=0 immediately, q_not=4'b1111; counting resumes from 0.
REQ-038 Default parameters (MAX=15) q=15, en=1, up=1 -> q=0, tc=1; q_not checked equal to ~q every cycle.
